// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared CPU definitions: opcodes, controller state codes, ALU/mux select encodings.
// Imported by the multi-cycle controller and by the ALU control block.
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  // ALU control class: add, subtract (compare), or decode from funct field
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state controls; last marks an instruction's final state and
  // waits marks states whose strobes depend on memory completion.
  typedef struct packed {
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       last;
    logic       waits;
  } ctrl_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_legal = 1'b1;
      default:                                       opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational state-to-control mapping for the multi-cycle controller.
// Unknown state codes decode to all-zero controls.
module ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.waits     = 1'b1;
      end
      S_DECODE: begin
        ctrl.ab_write     = 1'b1;
        ctrl.aluout_write = 1'b1;
        ctrl.alu_src_b    = SRCB_BOFF;
        ctrl.alu_op       = ALUOP_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRCB_IMM;
        ctrl.alu_op       = ALUOP_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_MEM_RD: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.mdr_write = 1'b1;
        ctrl.waits     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.last       = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.last      = 1'b1;
        ctrl.waits     = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRCB_REG;
        ctrl.alu_op       = ALUOP_FUNCT;
        ctrl.aluout_write = 1'b1;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.last      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.last          = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.last      = 1'b1;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.last      = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU main controller: state register, next-state logic and
// output qualification (memory-ready gating, branch PC enable, reset forcing).
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       ab_write,
  output logic       aluout_write,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   rdy;
  logic   gate;
  logic   en_ok;

  assign rdy = WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = rdy ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_I_EXEC:   state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Strobes of memory states fire only in the cycle the access completes,
  // so a stalled fetch or store never double-loads or double-reports.
  assign gate  = ~ctrl.waits | rdy;
  assign en_ok = ~rst;

  assign ir_write     = ctrl.ir_write & gate & en_ok;
  assign mdr_write    = ctrl.mdr_write & gate & en_ok;
  assign ab_write     = ctrl.ab_write & en_ok;
  assign aluout_write = ctrl.aluout_write & en_ok;
  assign pc_en        = ((ctrl.pc_write & gate) | (ctrl.pc_write_cond & zero)) & en_ok;
  assign iord         = ctrl.iord;
  assign mem_read     = ctrl.mem_read & en_ok;
  assign mem_write    = ctrl.mem_write & en_ok;
  assign reg_write    = ctrl.reg_write & en_ok;
  assign reg_dst      = ctrl.reg_dst;
  assign mem_to_reg   = ctrl.mem_to_reg;
  assign alu_src_a    = ctrl.alu_src_a;
  assign alu_src_b    = ctrl.alu_src_b;
  assign alu_op       = ctrl.alu_op;
  assign pc_source    = ctrl.pc_source;
  assign state        = state_q;
  assign instr_done   = ctrl.last & gate & en_ok;
  assign illegal_op   = (state_q == S_DECODE) & ~opcode_legal(opcode) & en_ok;

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_EN, 1, when 1 the memory states hold until mem_ready=1; when 0 mem_ready is ignored and treated as 1.
REQ-002 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have opcode  input  6  instruction bits [31:26], taken from the IR temp-register output.
REQ-005 SHALL have zero  input  1  ALU zero flag.
REQ-006 SHALL have mem_ready  input  1  memory access completes this cycle.
REQ-007 SHALL have ir_write, mdr_write, ab_write, aluout_write  output  1 each  load strobes for the IR, MDR, A/B and ALUOut temp registers.
REQ-008 SHALL have pc_en  output  1  PC load, equal to pc_write | (pc_write_cond & zero).
REQ-009 SHALL have iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath selects and enables.
REQ-010 SHALL have alu_src_b, alu_op, pc_source  output  2 each  mux selects and ALU control class.
REQ-011 SHALL have state  output  4  current state code, for debug.
REQ-012 SHALL have instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-013 SHALL have illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-014 SHALL be a Moore FSM; all outputs decode from the state register only, except pc_en, which also uses zero.
REQ-015 States SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
REQ-016 FETCH SHALL assert mem_read, ir_write, pc_write, alu_src_b=01, alu_op=00 and pc_source=00.
REQ-017 FETCH SHALL advance to DECODE only in a cycle with mem_ready=1; while it waits, ir_write and pc_write SHALL be gated low.
REQ-018 DECODE SHALL assert ab_write, aluout_write, alu_src_b=11 and alu_op=00 (branch target computation).
REQ-019 DECODE SHALL branch on opcode: 000000 -> R_EXEC, 100011/101011 -> MEM_ADDR, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> I_EXEC, any other -> FETCH with illegal_op=1.
REQ-020 MEM_ADDR SHALL assert alu_src_a, alu_src_b=10, alu_op=00 and aluout_write, then go to MEM_RD for 100011 or MEM_WR for 101011.
REQ-021 MEM_RD SHALL assert iord, mem_read and mdr_write (gated by mem_ready), and SHALL hold until mem_ready=1, then go to MEM_WB.
REQ-022 MEM_WR SHALL assert iord and mem_write, and SHALL hold until mem_ready=1, then go to FETCH with instr_done=1.
REQ-023 MEM_WB SHALL assert reg_write and mem_to_reg with reg_dst=0, then go to FETCH with instr_done=1.
REQ-024 R_EXEC SHALL assert alu_src_a, alu_src_b=00, alu_op=10 and aluout_write, then go to R_WB.
REQ-025 R_WB SHALL assert reg_write, reg_dst=1 and mem_to_reg=0, then go to FETCH with instr_done=1.
REQ-026 BRANCH SHALL assert alu_src_a, alu_src_b=00, alu_op=01, pc_write_cond and pc_source=01, then go to FETCH with instr_done=1.
REQ-027 JUMP SHALL assert pc_write and pc_source=10, then go to FETCH with instr_done=1.
REQ-028 I_EXEC SHALL assert alu_src_a, alu_src_b=10, alu_op=00 and aluout_write, then go to I_WB.
REQ-029 I_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0, then go to FETCH with instr_done=1.
REQ-030 Every output not listed for a state SHALL be 0 in that state.
REQ-031 mem_read and mem_write SHALL never be high in the same cycle.
REQ-032 Instruction latencies with no wait cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-033 An undefined state encoding SHALL return to FETCH on the next edge.

Reset
REQ-034 While rst=1, the next edge SHALL load FETCH, regardless of the current state or any pending wait.
REQ-035 While rst=1, all write and enable outputs (ir_write, mdr_write, ab_write, aluout_write, pc_en, mem_read, mem_write, reg_write, instr_done, illegal_op) SHALL be forced to 0.
REQ-036 The initial state at power-up SHALL be FETCH.

Structure
REQ-037 Opcode constants, state codes, and the alu_op, alu_src_b and pc_source encodings SHALL live in a shared cpu_defs include, used by both this block and the ALU control.
REQ-038 The block SHALL contain one sub-module, ctrl_decode, a purely combinational mapping from state to control outputs; the state register and next-state logic stay in the top module.

Verification
REQ-039 rst=1 for 2 cycles, then release -> state=0, all strobes 0 during reset, FETCH outputs in the first cycle after release.
REQ-040 lw (100011) with mem_ready tied 1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; instr_done at cycle 5.
REQ-041 beq with zero=1, then beq with zero=0 -> pc_en=1 in BRANCH for the first, pc_en=0 in BRANCH for the second.
REQ-042 sw with mem_ready=0 for 3 cycles in MEM_WR -> state holds at 5 for 4 cycles, mem_write held high, single instr_done pulse.
REQ-043 opcode 111111 -> illegal_op pulses in DECODE, next state FETCH, no reg_write or mem_write asserted.
REQ-044 rst asserted during MEM_RD wait -> FETCH on the next edge; mdr_write and reg_write never asserted.
